// File: rtl/phase_sequencer.sv
// Phase sequencer: replaces derived instruction/memory clocks with one-cycle
// enable strobes on the system clock, with hold, wait-timeout and halt control.
module phase_sequencer #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned WAIT_LIMIT  = 15,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 mem_req,
   input  logic                 mem_ready,
   input  logic                 halt_req,
   input  logic                 resume,
   output logic                 instr_en,
   output logic                 mem_en,
   output logic                 mem_wait,
   output logic                 halted,
   output logic                 timeout,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned WAIT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(WAIT_LIMIT);

   typedef enum logic [2:0] {
      S_HOLD,
      S_FETCH,
      S_EXEC,
      S_MEM,
      S_WAIT,
      S_HALT
   } state_t;

   state_t              state, state_nxt;
   logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
   logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
   logic                halt_pending, halt_pending_nxt;
   logic                timeout_nxt;
   logic                retire;
   logic                halt_now;

   // A halt request on the leaving edge counts as already pending.
   assign halt_now = halt_pending | halt_req;

   always_comb begin
      state_nxt        = state;
      hold_cnt_nxt     = hold_cnt;
      wait_cnt_nxt     = wait_cnt;
      halt_pending_nxt = halt_pending;
      timeout_nxt      = timeout;
      retire           = 1'b0;
      case (state)
         S_HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
               state_nxt    = S_FETCH;
               hold_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         S_FETCH: begin
            halt_pending_nxt = halt_now;
            state_nxt        = S_EXEC;
         end
         S_EXEC: begin
            halt_pending_nxt = halt_now;
            if (mem_req) begin
               state_nxt = S_MEM;
            end else begin
               retire    = 1'b1;
               state_nxt = halt_now ? S_HALT : S_FETCH;
            end
         end
         S_MEM: begin
            halt_pending_nxt = halt_now;
            if (mem_ready) begin
               retire    = 1'b1;
               state_nxt = halt_now ? S_HALT : S_FETCH;
            end else begin
               state_nxt    = S_WAIT;
               wait_cnt_nxt = WAIT_W'(1);
            end
         end
         S_WAIT: begin
            halt_pending_nxt = halt_now;
            if (mem_ready) begin
               retire    = 1'b1;
               state_nxt = halt_now ? S_HALT : S_FETCH;
            end else if ((WAIT_LIMIT != 0) && (wait_cnt == WAIT_MAX)) begin
               timeout_nxt = 1'b1;
               state_nxt   = S_HALT;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         S_HALT: begin
            if (resume) begin
               state_nxt   = S_FETCH;
               timeout_nxt = 1'b0;
            end
         end
         default: state_nxt = S_HOLD;
      endcase
      // Entering HALT consumes the pending request.
      if ((state_nxt == S_HALT) && (state != S_HALT)) begin
         halt_pending_nxt = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_HOLD;
         hold_cnt     <= '0;
         wait_cnt     <= '0;
         halt_pending <= 1'b0;
         timeout      <= 1'b0;
         instr_count  <= '0;
      end else begin
         state        <= state_nxt;
         hold_cnt     <= hold_cnt_nxt;
         wait_cnt     <= wait_cnt_nxt;
         halt_pending <= halt_pending_nxt;
         timeout      <= timeout_nxt;
         if (retire) begin
            instr_count <= instr_count + 1'b1;
         end
      end
   end

   // Strobes are registered copies of the next-state decode.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         instr_en <= 1'b0;
         mem_en   <= 1'b0;
         mem_wait <= 1'b0;
         halted   <= 1'b0;
      end else begin
         instr_en <= (state_nxt == S_FETCH);
         mem_en   <= (state_nxt == S_MEM);
         mem_wait <= (state_nxt == S_WAIT);
         halted   <= (state_nxt == S_HALT);
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: directed per-cycle vectors push the
// expected outputs; a negedge monitor pops and compares them.
module tb_phase_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req = 1'b0;
   logic        mem_ready = 1'b0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic        instr_en, mem_en, mem_wait, halted, timeout;
   logic [15:0] instr_count;

   phase_sequencer #(
      .HOLD_CYCLES(4),
      .WAIT_LIMIT (15),
      .CNT_WIDTH  (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .mem_req    (mem_req),
      .mem_ready  (mem_ready),
      .halt_req   (halt_req),
      .resume     (resume),
      .instr_en   (instr_en),
      .mem_en     (mem_en),
      .mem_wait   (mem_wait),
      .halted     (halted),
      .timeout    (timeout),
      .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  flags;
      logic [15:0] cnt;
      int          id;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;
   int   step = 0;

   // st: I=idle (HOLD/EXEC), F=FETCH, M=MEM, W=WAIT, H=HALT; flags {instr_en,mem_en,mem_wait,halted,timeout}
   function automatic logic [4:0] flags_of(input logic [7:0] st, input bit to);
      logic [4:0] f;
      case (st)
         "F":     f = 5'b10000;
         "M":     f = 5'b01000;
         "W":     f = 5'b00100;
         "H":     f = 5'b00010;
         default: f = 5'b00000;
      endcase
      f[0] = to;
      return f;
   endfunction

   task automatic push_exp(input logic [7:0] st, input int cnt, input bit to);
      exp_t e;
      e.flags = flags_of(st, to);
      e.cnt   = 16'(cnt);
      e.id    = step;
      sb_q.push_back(e);
      step++;
   endtask

   // Immediate comparison of the current outputs.
   task automatic check_now(input string tag, input logic [4:0] exp_flags, input int exp_cnt);
      logic [4:0] got;
      got = {instr_en, mem_en, mem_wait, halted, timeout};
      checks++;
      if (got !== exp_flags || instr_count !== 16'(exp_cnt)) begin
         failures++;
         $display("FAIL %s: flags got=%b exp=%b count got=%0d exp=%0d",
                  tag, got, exp_flags, instr_count, exp_cnt);
      end
   endtask

   // Apply inputs for the next rising edge and expect the state after it.
   task automatic cyc(input bit mr, input bit rdy, input bit hr, input bit rs,
                      input logic [7:0] st, input int cnt, input bit to = 1'b0);
      mem_req   = mr;
      mem_ready = rdy;
      halt_req  = hr;
      resume    = rs;
      push_exp(st, cnt, to);
      @(negedge clock);
      #1;
   endtask

   initial begin : monitor
      exp_t       e;
      logic [4:0] got;
      forever begin
         @(negedge clock);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {instr_en, mem_en, mem_wait, halted, timeout};
            checks++;
            if (got !== e.flags || instr_count !== e.cnt) begin
               failures++;
               $display("FAIL step%0d: flags got=%b exp=%b count got=%0d exp=%0d",
                        e.id, got, e.flags, instr_count, e.cnt);
            end
         end
      end
   end

   initial begin : driver
      // reset state, no clock edge needed
      #1;
      check_now("reset_state", 5'b00000, 0);
      push_exp("I", 0, 1'b0);
      @(negedge clock);
      #1;
      reset = 1'b0;

      // hold period then no-memory instructions
      repeat (3) cyc(0, 0, 0, 0, "I", 0);
      cyc(0, 0, 0, 0, "F", 0);
      cyc(0, 0, 0, 0, "I", 0);
      cyc(0, 0, 0, 0, "F", 1);
      cyc(0, 0, 0, 0, "I", 1);
      cyc(0, 0, 0, 0, "F", 2);
      cyc(0, 0, 0, 0, "I", 2);
      cyc(0, 0, 0, 0, "F", 3);

      // memory with immediate ready
      cyc(1, 1, 0, 0, "I", 3);
      cyc(1, 1, 0, 0, "M", 3);
      cyc(1, 1, 0, 0, "F", 4);
      cyc(1, 1, 0, 0, "I", 4);
      cyc(1, 1, 0, 0, "M", 4);
      cyc(1, 1, 0, 0, "F", 5);

      // three WAIT cycles, ready sampled leaving the third
      cyc(1, 0, 0, 0, "I", 5);
      cyc(1, 0, 0, 0, "M", 5);
      repeat (3) cyc(0, 0, 0, 0, "W", 5);
      cyc(0, 1, 0, 0, "F", 6);

      // wait timeout, then resume
      cyc(1, 0, 0, 0, "I", 6);
      cyc(1, 0, 0, 0, "M", 6);
      repeat (15) cyc(0, 0, 0, 0, "W", 6);
      cyc(0, 0, 0, 0, "H", 6, 1'b1);
      check_now("wait_expired", 5'b00011, 6);
      cyc(0, 0, 0, 0, "H", 6, 1'b1);
      cyc(0, 0, 0, 1, "F", 6);

      // halt pulse during MEM: access completes first
      cyc(1, 0, 0, 0, "I", 6);
      cyc(1, 0, 0, 0, "M", 6);
      cyc(0, 0, 1, 0, "W", 6);
      cyc(0, 0, 0, 0, "W", 6);
      cyc(0, 1, 0, 0, "H", 7);
      cyc(0, 0, 0, 0, "H", 7);
      cyc(0, 0, 1, 1, "F", 7);
      cyc(0, 0, 0, 0, "I", 7);
      cyc(0, 0, 0, 0, "F", 8);

      // halt from FETCH, halt_req ignored in HALT, pending cleared afterwards
      cyc(0, 0, 1, 0, "I", 8);
      cyc(0, 0, 0, 0, "H", 9);
      cyc(0, 0, 1, 0, "H", 9);
      cyc(0, 0, 0, 1, "F", 9);
      cyc(0, 0, 0, 0, "I", 9);
      cyc(0, 0, 0, 0, "F", 10);

      // reset mid-WAIT between edges, then hold restarts
      cyc(1, 0, 0, 0, "I", 10);
      cyc(1, 0, 0, 0, "M", 10);
      cyc(0, 0, 0, 0, "W", 10);
      mem_req   = 1'b0;
      mem_ready = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      #1;
      check_now("reset_mid_wait", 5'b00000, 0);
      push_exp("I", 0, 1'b0);
      @(negedge clock);
      #1;
      reset = 1'b0;
      repeat (3) cyc(0, 0, 0, 0, "I", 0);
      cyc(0, 0, 0, 0, "F", 0);
      cyc(0, 0, 0, 0, "I", 0);
      cyc(0, 0, 0, 0, "F", 1);

      @(negedge clock);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Single-clock phase sequencer that replaces the two derived clocks (instruction and memory) with one-cycle enable strobes on the system clock. It sits directly downstream of the base clock generator and drives the instruction-fetch and memory stages. It enforces a post-reset hold period and a fetch/execute/memory ordering with a memory-ready handshake and wait timeout. It also supports halt and resume and counts retired instructions.

## Interface
- HOLD_CYCLES, 4: clock edges held idle after reset release; minimum 1.
- WAIT_LIMIT, 15: maximum consecutive WAIT cycles before timeout; 0 disables the timeout.
- CNT_WIDTH, 16: width of the retired-instruction counter.

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_req  in  1  current instruction needs a memory access; sampled in EXEC.
- mem_ready  in  1  memory access complete; sampled in MEM and WAIT.
- halt_req  in  1  request to halt; may be a single-cycle pulse.
- resume  in  1  leave HALT; sampled only in HALT.
- instr_en  out  1  high exactly during FETCH cycles.
- mem_en  out  1  high exactly during MEM cycles.
- mem_wait  out  1  high exactly during WAIT cycles.
- halted  out  1  high exactly during HALT cycles.
- timeout  out  1  sticky flag: a WAIT timed out.
- instr_count  out  CNT_WIDTH  retired-instruction count.

## Operation
- States: HOLD, FETCH, EXEC, MEM, WAIT, HALT.
- All outputs are decoded from registered state and flags, so they are glitch-free.
- HOLD
  - hold_cnt counts 0..HOLD_CYCLES-1.
  - On the edge where hold_cnt==HOLD_CYCLES-1: go to FETCH.
  - halt_req is ignored in HOLD.
- FETCH: always goes to EXEC.
- EXEC
  - mem_req=1: go to MEM.
  - mem_req=0: retire the instruction, then go to HALT if a halt is pending, else FETCH.
- MEM
  - mem_ready=1: retire, then go to HALT if pending, else FETCH.
  - mem_ready=0: go to WAIT; wait_cnt=1.
- WAIT
  - mem_ready=1: retire, then go to HALT if pending, else FETCH.
  - mem_ready=0 and wait_cnt==WAIT_LIMIT (WAIT_LIMIT≠0): set timeout, go to HALT, no retire.
  - Otherwise: wait_cnt increments. wait_cnt is sized to hold WAIT_LIMIT.
- HALT
  - resume=1: go to FETCH and clear timeout.
  - halt_req is ignored in HALT; resume has priority.
- halt_pending
  - Set by halt_req in FETCH/EXEC/MEM/WAIT, including on the same edge that leaves those states.
  - Cleared on entry to HALT.
  - A memory access in progress always completes before halting.
- Retire: instr_count increments by 1 and wraps modulo 2^CNT_WIDTH.
- A timeout exit never retires.

## Timing
- Reset asserted, asynchronously and without a clock edge:
  - state=HOLD; hold_cnt, wait_cnt, halt_pending = 0.
  - instr_en, mem_en, mem_wait, halted, timeout = 0; instr_count=0.
- First instr_en: high in the cycle after the HOLD_CYCLES-th rising edge following reset deassertion.
- Cycles per instruction:
  - No memory: 2 cycles (FETCH, EXEC).
  - Memory, immediate ready: 3 cycles.
  - Each WAIT cycle adds 1.
- instr_count updates on the edge that leaves EXEC, MEM or WAIT with a retire. It is visible in the following FETCH or HALT cycle.
- halted rises in the cycle after the retiring edge.
- resume in HALT: instr_en is high on the next cycle.
- Reset mid-operation (any state) aborts immediately. No retire is counted, and the HOLD period restarts on release.

## Test plan
- HOLD_CYCLES=4, mem_req=0: all outputs 0 through 4 edges after release, then instr_en pattern 1,0,1,0… instr_count reads 1,2,3 at successive FETCHes.
- mem_req=1, mem_ready=1: period-3 pattern instr_en,–,mem_en. mem_wait never high. Count +1 per 3 cycles.
- mem_req=1, mem_ready raised in the 3rd WAIT cycle: mem_en 1 cycle, mem_wait 3 cycles, next cycle FETCH, count +1.
- WAIT_LIMIT=15, mem_ready stuck 0: mem_wait high 15 cycles, then halted=1 and timeout=1, count unchanged. resume pulse gives timeout=0 and instr_en next cycle.
- halt_req one-cycle pulse during MEM with mem_ready delayed 2 cycles: access completes, count +1, then halted=1. halt_req and resume together in HALT give FETCH next cycle.
- reset asserted mid-WAIT between edges: all outputs 0 and instr_count=0 before the next edge. After release, instr_en first high after the 4th edge.
